bus_response_tx: RTL and testbench

//  Terminates the daisy-chained register bus after the last core (e.g. logic analyzer) and

---
 rtl/bus_response_tx_if.sv | 24 ++
 rtl/bus_response_tx.sv | 177 +++++++++++++++++
 tb/tb_bus_response_tx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bus_response_tx_if.sv
// Bus-side and byte-stream signals of bus_response_tx: the register bus from the
// last core in the chain, the ASCII byte handshake toward the UART, and status.
interface bus_response_tx_if;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_i;
  logic        rw_i;
  logic        valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        overflow_o;
  logic        busy_o;

  modport slave (
    input  addr_i, wdata_i, rdata_i, rw_i, valid_i, ready_i,
    output data_o, valid_o, overflow_o, busy_o
  );

  modport master (
    output addr_i, wdata_i, rdata_i, rw_i, valid_i, ready_i,
    input  data_o, valid_o, overflow_o, busy_o
  );
endinterface

// File: rtl/bus_response_tx.sv
// Terminates the register bus and streams each read response as "M" + 4 hex digits + CR LF.
// Optional macro BUS_RESPONSE_TX_WRITE_ACK_EN also acknowledges writes with "W" CR LF.
module bus_response_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  bus_response_tx_if.slave bus
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

`ifdef BUS_RESPONSE_TX_WRITE_ACK_EN
  localparam int ENTRY_W = 17;
`else
  localparam int ENTRY_W = 16;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               empty, full;
  logic               push_req, push_ok, pop;
  logic [ENTRY_W-1:0] push_entry, head;
  logic               head_is_write;
  logic               overflow;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [15:0] resp, resp_n;
  logic        is_write, is_write_n;
  logic [7:0]  data_q, data_n;
  logic        valid_q, valid_n;

  // Address and write data never reach the host; only the strobe and read data matter.
  logic unused_bus;
  assign unused_bus = ^{bus.addr_i, bus.wdata_i};

`ifdef BUS_RESPONSE_TX_WRITE_ACK_EN
  assign push_req      = bus.valid_i;
  assign push_entry    = {bus.rw_i, bus.rdata_i};
  assign head_is_write = head[16];
`else
  assign push_req      = bus.valid_i && !bus.rw_i;
  assign push_entry    = bus.rdata_i;
  assign head_is_write = 1'b0;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [15:0] d,
                                            input logic wr);
    logic [7:0] b;
    if (wr) begin
      case (i)
        3'd0:    b = 8'h57;
        3'd1:    b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end else begin
      case (i)
        3'd0:    b = 8'h4D;
        3'd1:    b = hex_ascii(d[15:12]);
        3'd2:    b = hex_ascii(d[11:8]);
        3'd3:    b = hex_ascii(d[7:4]);
        3'd4:    b = hex_ascii(d[3:0]);
        3'd5:    b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end
    return b;
  endfunction

  // ---------------- response FIFO ----------------
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push_req && (!full || pop);

  // NOTE: storage needs no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // sees pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)             wr_ptr   <= wr_ptr + 1'b1;
      if (pop)                 rd_ptr   <= rd_ptr + 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // ---------------- frame FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      resp     <= '0;
      is_write <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      resp     <= resp_n;
      is_write <= is_write_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
    end
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    resp_n     = resp;
    is_write_n = is_write;
    data_n     = data_q;
    valid_n    = valid_q;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          resp_n     = head[15:0];
          is_write_n = head_is_write;
          idx_n      = 3'd0;
          data_n     = frame_byte(3'd0, head[15:0], head_is_write);
          valid_n    = 1'b1;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (valid_q && bus.ready_i) begin
          if (idx == (is_write ? 3'd2 : 3'd6)) begin
            // Chain straight into the next frame to avoid an idle gap.
            if (!empty) begin
              pop        = 1'b1;
              resp_n     = head[15:0];
              is_write_n = head_is_write;
              idx_n      = 3'd0;
              data_n     = frame_byte(3'd0, head[15:0], head_is_write);
            end else begin
              state_n = IDLE;
              idx_n   = 3'd0;
              data_n  = 8'h00;
              valid_n = 1'b0;
            end
          end else begin
            idx_n  = idx + 3'd1;
            data_n = frame_byte(idx + 3'd1, resp, is_write);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.overflow_o = overflow;
  assign bus.busy_o     = (state != IDLE) || !empty;

endmodule

// File: tb/tb_bus_response_tx.sv
// Directed bench for bus_response_tx: frames, stalls, overflow, mid-frame reset,
// write strobes and random back-pressure, all against hand-computed byte strings.
module tb_bus_response_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bus_response_tx_if bus ();

  bus_response_tx #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte monitor: a byte is taken when valid and ready are both high mid-cycle.
  logic [7:0] rx_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.valid_o) check("hold", bus.data_o, prev_data);
      if (bus.valid_o && bus.ready_i) rx_q.push_back(bus.data_o);
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_data  = bus.data_o;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_strobe(input logic rw, input logic [15:0] d);
    bus.valid_i = 1'b1;
    bus.rw_i    = rw;
    bus.rdata_i = d;
    bus.wdata_i = d;
    bus.addr_i  = 16'h00A0;
    step(1);
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget,
                            input bit rand_ready, output int cycles);
    cycles = 0;
    while (rx_q.size() < n && cycles < budget) begin
      if (rand_ready) bus.ready_i = 1'($urandom_range(0, 1));
      step(1);
      cycles++;
    end
    bus.ready_i = 1'b1;
    check({tag, "_count"}, rx_q.size(), n);
  endtask

  task automatic expect_frame(input string tag, input int n, input logic [55:0] exp);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hXX;
      check($sformatf("%s_b%0d", tag, i), b, exp[8*(n-1-i) +: 8]);
    end
  endtask

  int cyc;
  int stable;
  int busy_seen;

  initial begin
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.rdata_i = '0;
    bus.rw_i    = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    step(3);
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_data", bus.data_o, 8'h00);
    check("rst_ovf", bus.overflow_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    rst = 1'b0;
    step(2);

    // 1: single read, ready high, latency N+2
    bus.ready_i = 1'b1;
    bus_strobe(1'b0, 16'h0612);
    check("t1_lat1_valid", bus.valid_o, 1'b0);
    step(1);
    check("t1_lat2_valid", bus.valid_o, 1'b1);
    check("t1_lat2_data", bus.data_o, 8'h4D);
    wait_bytes("t1", 7, 50, 1'b0, cyc);
    expect_frame("t1", 7, 56'h4D_30_36_31_32_0D_0A);
    step(2);
    check("t1_valid_end", bus.valid_o, 1'b0);
    check("t1_busy_end", bus.busy_o, 1'b0);

    // 2: read with 20 cycles of back-pressure
    bus.ready_i = 1'b0;
    bus_strobe(1'b0, 16'hBEEF);
    step(1);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.valid_o && bus.data_o == 8'h4D) stable++;
      step(1);
    end
    check("t2_stall_stable", stable, 20);
    check("t2_no_accept", rx_q.size(), 0);
    bus.ready_i = 1'b1;
    wait_bytes("t2", 7, 50, 1'b0, cyc);
    expect_frame("t2", 7, 56'h4D_42_45_45_46_0D_0A);
    step(2);

    // 3: six back-to-back reads with ready low overflow a 4-deep FIFO
    bus.ready_i = 1'b0;
    for (int i = 0; i < 6; i++) bus_strobe(1'b0, 16'(i));
    step(1);
    check("t3_ovf", bus.overflow_o, 1'b1);
    check("t3_busy", bus.busy_o, 1'b1);
    check("t3_no_accept", rx_q.size(), 0);
    bus.ready_i = 1'b1;
    wait_bytes("t3", 35, 100, 1'b0, cyc);
    check("t3_no_gaps", cyc, 35);
    expect_frame("t3_f0", 7, 56'h4D_30_30_30_30_0D_0A);
    expect_frame("t3_f1", 7, 56'h4D_30_30_30_31_0D_0A);
    expect_frame("t3_f2", 7, 56'h4D_30_30_30_32_0D_0A);
    expect_frame("t3_f3", 7, 56'h4D_30_30_30_33_0D_0A);
    expect_frame("t3_f4", 7, 56'h4D_30_30_30_34_0D_0A);
    step(3);
    check("t3_extra", rx_q.size(), 0);
    check("t3_ovf_sticky", bus.overflow_o, 1'b1);
    check("t3_valid_end", bus.valid_o, 1'b0);

    // 4: reset while byte 3 of a frame is on the bus
    bus_strobe(1'b0, 16'h1234);
    wait_bytes("t4_pre", 3, 50, 1'b0, cyc);
    rst = 1'b1;
    #1;
    check("t4_rst_valid", bus.valid_o, 1'b0);
    check("t4_rst_busy", bus.busy_o, 1'b0);
    check("t4_rst_ovf", bus.overflow_o, 1'b0);
    step(2);
    rst = 1'b0;
    rx_q.delete();
    step(1);
    bus_strobe(1'b0, 16'h0001);
    wait_bytes("t4", 7, 50, 1'b0, cyc);
    expect_frame("t4", 7, 56'h4D_30_30_30_31_0D_0A);
    step(2);
    check("t4_extra", rx_q.size(), 0);

    // 5: write strobe
    bus_strobe(1'b1, 16'h0069);
`ifdef BUS_RESPONSE_TX_WRITE_ACK_EN
    wait_bytes("t5", 3, 50, 1'b0, cyc);
    expect_frame("t5", 3, 56'h57_0D_0A);
    step(2);
    check("t5_busy_end", bus.busy_o, 1'b0);
`else
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy_o || bus.valid_o) busy_seen++;
      step(1);
    end
    check("t5_no_busy", busy_seen, 0);
    check("t5_no_bytes", rx_q.size(), 0);
`endif

    // 6: random back-pressure
    bus.ready_i = 1'b0;
    bus_strobe(1'b0, 16'hA5F0);
    wait_bytes("t6", 7, 400, 1'b1, cyc);
    expect_frame("t6", 7, 56'h4D_41_35_46_30_0D_0A);
    step(3);
    check("t6_valid_end", bus.valid_o, 1'b0);
    check("t6_extra", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
